debounce_filter: RTL and testbench

Debounce and edge-event stage that sits directly downstream of the single-bit D flip-flop and consumes its registered `q` output. It accepts a new level only after the input has held steady for a programmable number of qualified samples. It outputs three things: a clean level, one-cycle rise/fall pulses and a wrapping rise-event count. Typical use is cleaning a mechanical switch or a noisy status bit before it reaches control logic.

---
 rtl/debounce_filter.sv | 116 +++++++++++
 tb/tb_debounce_filter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/debounce_filter.sv
// Debounce and edge-event stage: accepts a new level after STABLE_CYCLES equal qualified samples.
// Optional 2-flop input synchronizer is compiled in with `define DEBOUNCE_SYNC_EN.
module debounce_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             sample_en,
    output logic             q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] rise_cnt
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW     = 2'b00,
        WAIT_HI = 2'b01,
        HIGH    = 2'b10,
        WAIT_LO = 2'b11
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          s;

`ifdef DEBOUNCE_SYNC_EN
    logic sync1;
    logic sync2;

    // Synchronizer runs every cycle; sample_en only qualifies the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = d;
`endif

    // Pulses default low each cycle, so a frozen (sample_en=0) cycle never pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOW;
            cnt      <= '0;
            q        <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            rise_cnt <= '0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                LOW: begin
                    if (sample_en && s) begin
                        state <= WAIT_HI;
                        cnt   <= CW'(1);
                    end
                end
                WAIT_HI: begin
                    if (sample_en) begin
                        if (!s) begin
                            state <= LOW;
                            cnt   <= '0;
                        end else if (cnt == LAST) begin
                            state    <= HIGH;
                            cnt      <= '0;
                            q        <= 1'b1;
                            rise     <= 1'b1;
                            rise_cnt <= rise_cnt + CNT_W'(1);
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HIGH: begin
                    if (sample_en && !s) begin
                        state <= WAIT_LO;
                        cnt   <= CW'(1);
                    end
                end
                WAIT_LO: begin
                    if (sample_en) begin
                        if (s) begin
                            state <= HIGH;
                            cnt   <= '0;
                        end else if (cnt == LAST) begin
                            state <= LOW;
                            cnt   <= '0;
                            q     <= 1'b0;
                            fall  <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= LOW;
                    cnt   <= '0;
                    q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_filter.sv
// Directed self-checking bench for debounce_filter (STABLE_CYCLES=4, CNT_W=8).
// Expected timings shift by the synchronizer latency when DEBOUNCE_SYNC_EN is defined.
module tb_debounce_filter;

`ifdef DEBOUNCE_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       d;
    logic       sample_en;
    logic       q;
    logic       rise;
    logic       fall;
    logic [7:0] rise_cnt;

    int         assertCount = 0;
    int         failCount   = 0;
    logic [7:0] expRiseCnt  = 8'd0;

    debounce_filter #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .sample_en(sample_en),
        .q        (q),
        .rise     (rise),
        .fall     (fall),
        .rise_cnt (rise_cnt)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic dv, input logic en);
        rst       = r;
        d         = dv;
        sample_en = en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Hold d at lvl for a number of edges; acceptAt is the edge index where the level is accepted (-1: never).
    task automatic holdLevel(input string tag, input logic lvl, input int edges, input int acceptAt, input logic startQ);
        logic expQ;
        for (int k = 0; k < edges; k++) begin
            applyStimulus(1'b0, lvl, 1'b1);
            tick();
            expQ = (acceptAt >= 0 && k >= acceptAt) ? lvl : startQ;
            if (k == acceptAt && lvl) expRiseCnt = expRiseCnt + 8'd1;
            checkOutput({tag, "_q"},    {7'd0, q},    {7'd0, expQ});
            checkOutput({tag, "_rise"}, {7'd0, rise}, {7'd0, (k == acceptAt) && lvl});
            checkOutput({tag, "_fall"}, {7'd0, fall}, {7'd0, (k == acceptAt) && !lvl});
            checkOutput({tag, "_cnt"},  rise_cnt,     expRiseCnt);
        end
    endtask

    initial begin
        // Reset held with d toggling, then one released cycle at d=0.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, (i % 2) == 0, 1'b1);
            tick();
            checkOutput("rst_q",    {7'd0, q},    8'd0);
            checkOutput("rst_rise", {7'd0, rise}, 8'd0);
            checkOutput("rst_fall", {7'd0, fall}, 8'd0);
            checkOutput("rst_cnt",  rise_cnt,     8'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("post_rst_q",    {7'd0, q},    8'd0);
        checkOutput("post_rst_rise", {7'd0, rise}, 8'd0);
        checkOutput("post_rst_cnt",  rise_cnt,     8'd0);

        // Clean rise: accepted on E3 (+L), rise gone on the following edge.
        holdLevel("clean_rise", 1'b1, 5 + L, 3 + L, 1'b0);
        checkOutput("clean_rise_total", rise_cnt, 8'd1);

        // Back to LOW, then a 3-sample glitch that must be discarded.
        holdLevel("fall1", 1'b0, 4 + L, 3 + L, 1'b1);
        holdLevel("glitch_hi", 1'b1, 3, -1, 1'b0);
        holdLevel("glitch_lo", 1'b0, 4 + L, -1, 1'b0);
        checkOutput("glitch_total", rise_cnt, 8'd1);

        // Rise, then a 3-sample low glitch returning on the boundary edge, then a real fall.
        holdLevel("rise2", 1'b1, 4 + L, 3 + L, 1'b0);
        holdLevel("bnd_lo", 1'b0, 3, -1, 1'b1);
        holdLevel("bnd_hi", 1'b1, 4 + L, -1, 1'b1);
        holdLevel("fall2", 1'b0, 4 + L, 3 + L, 1'b1);

        // Qualified sampling: tick at cycles 1,4,7,10 -> rise on cycle 10.
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < L; i++) begin
            tick();
            checkOutput("qual_fill_q", {7'd0, q}, 8'd0);
        end
        for (int c = 1; c <= 12; c++) begin
            applyStimulus(1'b0, 1'b1, (c % 3) == 1);
            tick();
            checkOutput("qual_rise", {7'd0, rise}, {7'd0, c == 10});
            checkOutput("qual_q",    {7'd0, q},    {7'd0, c >= 10});
            checkOutput("qual_fall", {7'd0, fall}, 8'd0);
        end
        expRiseCnt = 8'd3;
        checkOutput("qual_total", rise_cnt, 8'd3);
        holdLevel("fall3", 1'b0, 4 + L, 3 + L, 1'b1);

        // Reset while WAIT_HI holds cnt=2: no rise, counter cleared.
        for (int i = 0; i < 2 + L; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            tick();
            checkOutput("mid_pre_q", {7'd0, q}, 8'd0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("mid_rst_q",    {7'd0, q},    8'd0);
        checkOutput("mid_rst_rise", {7'd0, rise}, 8'd0);
        checkOutput("mid_rst_cnt",  rise_cnt,     8'd0);
        expRiseCnt = 8'd0;
        holdLevel("mid_after", 1'b0, 4 + L, -1, 1'b0);

        // 256 accepted rises wrap rise_cnt back to 0.
        for (int n = 0; n < 256; n++) begin
            holdLevel("wrap_rise", 1'b1, 4 + L, 3 + L, 1'b0);
            if (n == 254) checkOutput("wrap_255", rise_cnt, 8'd255);
            holdLevel("wrap_fall", 1'b0, 4 + L, 3 + L, 1'b1);
        end
        checkOutput("wrap_zero", rise_cnt, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
